// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request strobe per fetch, one response strobe per request, at most
// one transaction in flight.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch stage side: issues requests, consumes responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side: accepts requests, returns responses.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// buffers the returned word for the IF/ID register, and handles downstream
// stalls plus EX-stage redirects, discarding responses of squashed fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  fetch_unit_if.master       imem,
  output logic [31:0]        instruction,
  output logic [31:0]        PCF,
  output logic [31:0]        PCPlus4F,
  output logic               FetchBusy
);

  // BOOT : idle cycle after reset so no request coincides with reset release
  // FETCH: request strobe for the current PC
  // WAIT : request outstanding, response still wanted
  // DROP : request outstanding, response belongs to a squashed fetch
  // READY: word held and presented downstream
  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    READY = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Redirect targets are word aligned; low address bits are forced to zero.
  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  // Target alignment and sequential PC (wraps modulo 2^32).
  always_comb begin
    target_aligned = PCTargetE & ~32'd3;
    pc_plus4       = pc_q + 32'd4;
  end

  // State, PC and instruction-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, next-PC, buffer capture and all stage outputs.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = 32'd0;
    instruction    = NOP_INSTR;
    FetchBusy      = 1'b1;
    PCF            = pc_q;
    PCPlus4F       = pc_plus4;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_q;
        // A redirect here squashes the request just issued; its response
        // still has to be absorbed in DROP. StallF is irrelevant here.
        if (PCSrcE) begin
          pc_d    = target_aligned;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (PCSrcE) begin
          pc_d = target_aligned;
          // If the stale response lands in the same cycle it is consumed
          // and dropped now, so the new fetch can start immediately.
          state_d = imem.imem_rvalid ? FETCH : DROP;
        end else if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = READY;
        end
      end

      DROP: begin
        // Further redirects only retarget the PC; the outstanding stale
        // response must still be swallowed before a new request goes out.
        if (PCSrcE) begin
          pc_d = target_aligned;
        end
        if (imem.imem_rvalid) begin
          state_d = FETCH;
        end
      end

      READY: begin
        instruction = instr_q;
        FetchBusy   = 1'b0;
        if (PCSrcE) begin
          pc_d    = target_aligned;
          state_d = FETCH;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit. The bench plays the instruction
// memory by hand: each table row is one clock cycle of inputs (including the
// memory response) together with the outputs expected during that cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] instruction;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FetchBusy;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h00000000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem        (bus.master),
    .instruction (instruction),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .FetchBusy   (FetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  // Memory-protocol monitor: a response needs an outstanding request and a
  // new request may not be issued while one is outstanding.
  logic outstanding;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 1'b0;
    end else begin
      assert (!(bus.imem_rvalid && !outstanding))
        else $error("protocol violation: response with no outstanding request");
      assert (!(bus.imem_req && outstanding))
        else $error("protocol violation: second outstanding request");
      if (bus.imem_rvalid) outstanding <= 1'b0;
      if (bus.imem_req)    outstanding <= 1'b1;
    end
  end

  task automatic add(input logic st, input logic ps, input logic [31:0] tg,
                     input logic rv, input logic [31:0] rd,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] einstr, input logic [31:0] epc,
                     input logic ebusy);
    vec_t v;
    v.stall = st; v.pcsrc = ps; v.target = tg; v.rvalid = rv; v.rdata = rd;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_instr = einstr;
    v.exp_pc = epc; v.exp_busy = ebusy;
    vecs.push_back(v);
  endtask

  // Compare all stage outputs against one record; one line per transaction.
  task automatic check_out(input vec_t v, input string tag);
    logic [31:0] exp_pc4;
    logic        bad;
    exp_pc4 = v.exp_pc + 32'd4;
    bad = (bus.imem_req !== v.exp_req)
       || (v.exp_req && (bus.imem_addr !== v.exp_addr))
       || (instruction !== v.exp_instr)
       || (PCF !== v.exp_pc)
       || (PCPlus4F !== exp_pc4)
       || (FetchBusy !== v.exp_busy);
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got req=%0b addr=%h instr=%h pc=%h pc4=%h busy=%0b, want req=%0b addr=%h instr=%h pc=%h pc4=%h busy=%0b",
               tag, bus.imem_req, bus.imem_addr, instruction, PCF, PCPlus4F, FetchBusy,
               v.exp_req, v.exp_addr, v.exp_instr, v.exp_pc, exp_pc4, v.exp_busy);
    end else begin
      $display("ok   %s: req=%0b addr=%h instr=%h pc=%h busy=%0b",
               tag, bus.imem_req, bus.imem_addr, instruction, PCF, FetchBusy);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check outputs.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    StallF          = v.stall;
    PCSrcE          = v.pcsrc;
    PCTargetE       = v.target;
    bus.imem_rvalid = v.rvalid;
    bus.imem_rdata  = v.rdata;
    #1;
    check_out(v, tag);
  endtask

  initial begin
    vec_t rv;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;

    //  st ps target        rv rdata           req addr          instr          pc            busy
    // c1 BOOT, c2 FETCH @0, c3 WAIT with 1-cycle response
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         NOP,           32'h0,        1);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h0,         NOP,           32'h0,        1);
    add(0, 0, 32'h0,        1, 32'h00500093,   0, 32'h0,         NOP,           32'h0,        1);
    // c4..c8 READY with StallF held 5 cycles, c9 advance
    for (int i = 0; i < 5; i++)
      add(1, 0, 32'h0,      0, 32'h0,          0, 32'h0,         32'h00500093,  32'h0,        0);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         32'h00500093,  32'h0,        0);
    // c10 FETCH @4 (StallF ignored), c11-c12 WAIT 2-cycle memory
    add(1, 0, 32'h0,        0, 32'h0,          1, 32'h4,         NOP,           32'h4,        1);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         NOP,           32'h4,        1);
    add(0, 0, 32'h0,        1, 32'hAAAA0001,   0, 32'h0,         NOP,           32'h4,        1);
    // c13 READY: redirect together with stall, redirect wins
    add(1, 1, 32'h200,      0, 32'h0,          0, 32'h0,         32'hAAAA0001,  32'h4,        0);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h200,       NOP,           32'h200,      1);
    // c15 WAIT: redirect coincident with response, data discarded
    add(0, 1, 32'h303,      1, 32'hDEAD0000,   0, 32'h0,         NOP,           32'h200,      1);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h300,       NOP,           32'h300,      1);
    add(0, 0, 32'h0,        1, 32'h11110000,   0, 32'h0,         NOP,           32'h300,      1);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         32'h11110000,  32'h300,      0);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h304,       NOP,           32'h304,      1);
    // c20 WAIT: redirect to 0x103, stale response arrives 3 cycles after request
    add(0, 1, 32'h103,      0, 32'h0,          0, 32'h0,         NOP,           32'h304,      1);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         NOP,           32'h100,      1);
    add(0, 0, 32'h0,        1, 32'hBADBAD00,   0, 32'h0,         NOP,           32'h100,      1);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h100,       NOP,           32'h100,      1);
    add(0, 0, 32'h0,        1, 32'h12345678,   0, 32'h0,         NOP,           32'h100,      1);
    // c25 READY: redirect to top word, then wraparound advance
    add(0, 1, 32'hFFFFFFFC, 0, 32'h0,          0, 32'h0,         32'h12345678,  32'h100,      0);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'hFFFFFFFC,  NOP,           32'hFFFFFFFC, 1);
    add(0, 0, 32'h0,        1, 32'hCAFE0001,   0, 32'h0,         NOP,           32'hFFFFFFFC, 1);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         32'hCAFE0001,  32'hFFFFFFFC, 0);
    // c29 FETCH @0 with redirect -> DROP, c30 second redirect in DROP
    add(0, 1, 32'h40,       0, 32'h0,          1, 32'h0,         NOP,           32'h0,        1);
    add(0, 1, 32'h47,       0, 32'h0,          0, 32'h0,         NOP,           32'h40,       1);
    add(0, 0, 32'h0,        1, 32'h5555AAAA,   0, 32'h0,         NOP,           32'h44,       1);
    add(0, 0, 32'h0,        0, 32'h0,          1, 32'h44,        NOP,           32'h44,       1);
    add(0, 0, 32'h0,        0, 32'h0,          0, 32'h0,         NOP,           32'h44,       1);

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rv.stall = 0; rv.pcsrc = 0; rv.target = 0; rv.rvalid = 0; rv.rdata = 0;
    rv.exp_req = 0; rv.exp_addr = 0; rv.exp_instr = NOP; rv.exp_pc = 32'h0; rv.exp_busy = 1;
    check_out(rv, "reset_hold");

    // Release just after a rising edge so the following cycle is BOOT.
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("cycle%0d", i + 1));

    // Asynchronous reset asserted mid-WAIT, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_out(rv, "async_reset_wait");
    @(posedge clk);
    #1;
    check_out(rv, "reset_after_edge");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
